// File: rtl/instruction_fetch_pkg.sv
// Shared definitions for the fetch stage and the instruction decoder:
// instruction field positions, branch-select encodings, opcode limit and
// fetch FSM state encodings.
// Optional feature macro: IFETCH_ILLEGAL_TRAP_EN (adds the TRAP state).
package instruction_fetch_pkg;

   // Instruction layout: opcode[16:12], DA[11:9], AA[8:6], BA[5:3], low[2:0]
   localparam int OPC_MSB = 16;
   localparam int OPC_LSB = 12;
   localparam int DA_MSB  = 11;
   localparam int DA_LSB  = 9;
   localparam int AA_MSB  = 8;
   localparam int AA_LSB  = 6;
   localparam int BA_MSB  = 5;
   localparam int BA_LSB  = 3;
   localparam int LOW_MSB = 2;
   localparam int LOW_LSB = 0;

   // Branch offset is {DA, low}, a 6-bit two's complement value
   localparam int OFF_W = 6;

   // Branch select encodings produced by the decoder
   localparam logic [1:0] BS_INC  = 2'b00;
   localparam logic [1:0] BS_COND = 2'b01;
   localparam logic [1:0] BS_JMP  = 2'b10;
   localparam logic [1:0] BS_BRA  = 2'b11;

   // Highest legal opcode
   localparam logic [4:0] OPCODE_MAX = 5'd20;

   // Fetch FSM states
   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FETCH = 2'd1,
      S_ISSUE = 2'd2
`ifdef IFETCH_ILLEGAL_TRAP_EN
      ,
      S_TRAP  = 2'd3
`endif
   } fetch_state_e;

endpackage

// File: rtl/instruction_fetch_next_pc_calc.sv
// Next-PC computation: sign-extends the 6-bit branch offset, resolves the
// conditional branch against the zero flag and selects among increment,
// relative branch and register jump. Purely combinational; all arithmetic
// wraps modulo 2^PC_W.
module instruction_fetch_next_pc_calc
   import instruction_fetch_pkg::*;
#(
   parameter int PC_W = 8
) (
   input  logic [PC_W-1:0]  pc,
   input  logic [OFF_W-1:0] off_raw,
   input  logic [1:0]       bs,
   input  logic             ps,
   input  logic             zero,
   input  logic [PC_W-1:0]  jump_addr,
   output logic [PC_W-1:0]  next_pc
);

   logic [PC_W-1:0] off;
   logic [PC_W-1:0] pc_inc;
   logic [PC_W-1:0] pc_off;
   logic            taken;

   // Candidate addresses and the conditional-branch decision
   always_comb begin
      off    = {{(PC_W-OFF_W){off_raw[OFF_W-1]}}, off_raw};
      pc_inc = pc + PC_W'(1);
      pc_off = pc + off;
      // ps=0 branches on zero=1, ps=1 branches on zero=0
      taken  = (zero != ps);
   end

   // Four-way next-PC select
   always_comb begin
      next_pc = pc_inc;
      case (bs)
         BS_INC:  next_pc = pc_inc;
         BS_COND: next_pc = taken ? pc_off : pc_inc;
         BS_JMP:  next_pc = jump_addr;
         BS_BRA:  next_pc = pc_off;
         default: next_pc = pc_inc;
      endcase
   end

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: owns the PC and the instruction register, reads
// program memory and holds each word on the decoder input until execute
// reports completion, then advances the PC from the branch controls.
// Optional feature macro: IFETCH_ILLEGAL_TRAP_EN (illegal-opcode trap).
//
// Handshakes:
//   imem  : imem_req is high for the whole FETCH state; a word is accepted on
//           the first rising edge with imem_req=1 and imem_valid=1 (valid may
//           arrive in the same cycle as the request). imem_valid with
//           imem_req=0 is ignored.
//   decode: instr_valid=1 marks an unexecuted word in instr_out, held stable;
//           it is retired on the edge where instr_valid=1 and exec_done=1.
//           exec_done with instr_valid=0 is ignored.
module instruction_fetch
   import instruction_fetch_pkg::*;
#(
   parameter int              PC_W     = 8,
   parameter int              INSTR_W  = 17,
   parameter logic [PC_W-1:0] RESET_PC = '0
`ifdef IFETCH_ILLEGAL_TRAP_EN
   ,
   parameter logic [PC_W-1:0] TRAP_VECTOR = '1
`endif
) (
   input  logic               clk,
   input  logic               rst,
   output logic [PC_W-1:0]    imem_addr,
   output logic               imem_req,
   input  logic [INSTR_W-1:0] imem_data,
   input  logic               imem_valid,
   output logic [INSTR_W-1:0] instr_out,
   output logic               instr_valid,
   input  logic               exec_done,
   input  logic [1:0]         bs,
   input  logic               ps,
   input  logic               zero,
   input  logic [PC_W-1:0]    jump_addr,
   output logic [PC_W-1:0]    pc_out,
   output logic               illegal,
   output fetch_state_e       state_dbg
);

   fetch_state_e       state;
   fetch_state_e       next_state;
   logic [PC_W-1:0]    pc;
   logic [INSTR_W-1:0] ir;
   logic [PC_W-1:0]    next_pc;

   assign imem_addr = pc;
   assign instr_out = ir;
   assign state_dbg = state;

   instruction_fetch_next_pc_calc #(
      .PC_W (PC_W)
   ) u_next_pc (
      .pc        (pc),
      .off_raw   ({ir[DA_MSB:DA_LSB], ir[LOW_MSB:LOW_LSB]}),
      .bs        (bs),
      .ps        (ps),
      .zero      (zero),
      .jump_addr (jump_addr),
      .next_pc   (next_pc)
   );

   // State register; reset wins in every state and abandons any fetch
   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= next_state;
   end

   // Next-state logic
   always_comb begin
      next_state = state;
      case (state)
         S_IDLE:  next_state = S_FETCH;
         S_FETCH: begin
            if (imem_valid) begin
`ifdef IFETCH_ILLEGAL_TRAP_EN
               if (imem_data[OPC_MSB:OPC_LSB] > OPCODE_MAX) next_state = S_TRAP;
               else                                         next_state = S_ISSUE;
`else
               next_state = S_ISSUE;
`endif
            end
         end
         S_ISSUE: if (exec_done) next_state = S_FETCH;
`ifdef IFETCH_ILLEGAL_TRAP_EN
         S_TRAP:  next_state = S_FETCH;
`endif
         default: next_state = S_IDLE;
      endcase
   end

   // Outputs decoded from the current state
   always_comb begin
      imem_req    = 1'b0;
      instr_valid = 1'b0;
      illegal     = 1'b0;
      case (state)
         S_FETCH: imem_req    = 1'b1;
         S_ISSUE: instr_valid = 1'b1;
`ifdef IFETCH_ILLEGAL_TRAP_EN
         S_TRAP:  illegal     = 1'b1;
`endif
         default: ;
      endcase
   end

   // PC, IR and link address; IR only changes on an accepted fetch
   always_ff @(posedge clk) begin
      if (rst) begin
         pc     <= RESET_PC;
         ir     <= '0;
         pc_out <= RESET_PC;
      end else begin
         case (state)
            S_FETCH: begin
               if (imem_valid) begin
                  ir     <= imem_data;
                  pc_out <= pc;
               end
            end
            S_ISSUE: if (exec_done) pc <= next_pc;
`ifdef IFETCH_ILLEGAL_TRAP_EN
            S_TRAP:  pc <= TRAP_VECTOR;
`endif
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_instruction_fetch.sv
// Testbench for instruction_fetch: reset state, sequential fetch, a table of
// branch/jump vectors, wait states, reset mid-fetch and the opcode limit.
// Honours IFETCH_ILLEGAL_TRAP_EN for the illegal-opcode expectations.
module tb_instruction_fetch;
   import instruction_fetch_pkg::*;

   localparam int PC_W    = 8;
   localparam int INSTR_W = 17;

   logic               clk = 1'b0;
   logic               rst;
   logic [PC_W-1:0]    imem_addr;
   logic               imem_req;
   logic [INSTR_W-1:0] imem_data;
   logic               imem_valid;
   logic [INSTR_W-1:0] instr_out;
   logic               instr_valid;
   logic               exec_done;
   logic [1:0]         bs;
   logic               ps;
   logic               zero;
   logic [PC_W-1:0]    jump_addr;
   logic [PC_W-1:0]    pc_out;
   logic               illegal;
   fetch_state_e       state_dbg;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      logic [7:0]  pc;
      logic [16:0] word;
      logic [1:0]  bs;
      logic        ps;
      logic        zero;
      logic [7:0]  jmp;
      logic [7:0]  exp_pc;
   } vec_t;

   vec_t vecs[12];

   instruction_fetch #(
      .PC_W    (PC_W),
      .INSTR_W (INSTR_W)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .imem_addr   (imem_addr),
      .imem_req    (imem_req),
      .imem_data   (imem_data),
      .imem_valid  (imem_valid),
      .instr_out   (instr_out),
      .instr_valid (instr_valid),
      .exec_done   (exec_done),
      .bs          (bs),
      .ps          (ps),
      .zero        (zero),
      .jump_addr   (jump_addr),
      .pc_out      (pc_out),
      .illegal     (illegal),
      .state_dbg   (state_dbg)
   );

   // Clock
   always #5 clk = ~clk;

   // Watchdog
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Zero-wait memory reply; called at a negedge while in FETCH
   task automatic feed(input logic [16:0] word);
      imem_valid = 1'b1;
      imem_data  = word;
      tick();
      imem_valid = 1'b0;
   endtask

   // Retire the word in ISSUE with the given branch controls
   task automatic retire(input logic [1:0] b, input logic p, input logic z, input logic [7:0] j);
      bs        = b;
      ps        = p;
      zero      = z;
      jump_addr = j;
      exec_done = 1'b1;
      tick();
      exec_done = 1'b0;
   endtask

   // Steer the PC to a target via a filler word and a register jump
   task automatic goto_pc(input logic [7:0] target);
      feed(17'h00000);
      retire(BS_JMP, 1'b0, 1'b0, target);
   endtask

   initial begin
      // pc, word, bs, ps, zero, jump, expected next fetch address
      vecs[0]  = '{8'h02, 17'h0AE04, BS_BRA,  1'b0, 1'b0, 8'h00, 8'hFE}; // -4 wraps
      vecs[1]  = '{8'h10, 17'h0A005, BS_COND, 1'b0, 1'b1, 8'h00, 8'h15}; // ps0 z1 taken
      vecs[2]  = '{8'h10, 17'h0A005, BS_COND, 1'b0, 1'b0, 8'h00, 8'h11}; // ps0 z0 not
      vecs[3]  = '{8'h10, 17'h0A005, BS_COND, 1'b1, 1'b1, 8'h00, 8'h11}; // ps1 z1 not
      vecs[4]  = '{8'h10, 17'h0A005, BS_COND, 1'b1, 1'b0, 8'h00, 8'h15}; // ps1 z0 taken
      vecs[5]  = '{8'h30, 17'h03000, BS_JMP,  1'b0, 1'b0, 8'h5A, 8'h5A}; // jump reg
      vecs[6]  = '{8'hFF, 17'h01FFF, BS_INC,  1'b0, 1'b0, 8'h00, 8'h00}; // inc wraps
      vecs[7]  = '{8'hFF, 17'h00003, BS_BRA,  1'b0, 1'b0, 8'h00, 8'h02}; // +3 wraps
      vecs[8]  = '{8'h80, 17'h00607, BS_BRA,  1'b0, 1'b0, 8'h00, 8'h9F}; // max +31
      vecs[9]  = '{8'h05, 17'h00800, BS_COND, 1'b0, 1'b1, 8'h00, 8'hE5}; // min -32
      vecs[10] = '{8'h02, 17'h0AE04, BS_COND, 1'b1, 1'b1, 8'h00, 8'h03}; // not taken
      vecs[11] = '{8'h40, 17'h0AE04, BS_JMP,  1'b0, 1'b0, 8'h00, 8'h00}; // jump to 0

      rst        = 1'b1;
      imem_data  = '0;
      imem_valid = 1'b0;
      exec_done  = 1'b0;
      bs         = BS_INC;
      ps         = 1'b0;
      zero       = 1'b0;
      jump_addr  = '0;

      // Reset state
      repeat (3) tick();
      chk("rst_imem_req",    32'(imem_req),    32'h0);
      chk("rst_instr_valid", 32'(instr_valid), 32'h0);
      chk("rst_pc_out",      32'(pc_out),      32'h0);
      chk("rst_illegal",     32'(illegal),     32'h0);
      chk("rst_instr_out",   32'(instr_out),   32'h0);
      chk("rst_imem_addr",   32'(imem_addr),   32'h0);
      chk("rst_state",       32'(state_dbg),   32'(S_IDLE));
      rst = 1'b0;
      tick();
      chk("idle_to_fetch", 32'(state_dbg), 32'(S_FETCH));

      // Sequential fetch, zero-wait memory, two cycles per instruction
      for (int i = 0; i < 4; i++) begin
         logic [16:0] w;
         w = 17'(i * 3 + 1);
         chk($sformatf("seq%0d_addr", i),  32'(imem_addr), 32'(i));
         chk($sformatf("seq%0d_req", i),   32'(imem_req),  32'h1);
         feed(w);
         chk($sformatf("seq%0d_valid", i), 32'(instr_valid), 32'h1);
         chk($sformatf("seq%0d_ir", i),    32'(instr_out),   32'(w));
         chk($sformatf("seq%0d_pcout", i), 32'(pc_out),      32'(i));
         chk($sformatf("seq%0d_noreq", i), 32'(imem_req),    32'h0);
         retire(BS_INC, 1'b0, 1'b0, 8'h00);
         chk($sformatf("seq%0d_drop", i),  32'(instr_valid), 32'h0);
      end

      // Branch / jump vector table
      for (int k = 0; k < 12; k++) begin
         goto_pc(vecs[k].pc);
         chk($sformatf("vec%0d_fetch_addr", k), 32'(imem_addr), 32'(vecs[k].pc));
         feed(vecs[k].word);
         chk($sformatf("vec%0d_ir", k),    32'(instr_out), 32'(vecs[k].word));
         chk($sformatf("vec%0d_pcout", k), 32'(pc_out),    32'(vecs[k].pc));
         retire(vecs[k].bs, vecs[k].ps, vecs[k].zero, vecs[k].jmp);
         chk($sformatf("vec%0d_next", k),  32'(imem_addr), 32'(vecs[k].exp_pc));
         chk($sformatf("vec%0d_req", k),   32'(imem_req),  32'h1);
      end

      // Memory wait states; exec_done in FETCH is ignored
      goto_pc(8'h20);
      for (int c = 0; c < 3; c++) begin
         exec_done = (c == 1);
         bs        = BS_JMP;
         jump_addr = 8'h77;
         tick();
         exec_done = 1'b0;
         chk($sformatf("wait%0d_req", c),   32'(imem_req),    32'h1);
         chk($sformatf("wait%0d_addr", c),  32'(imem_addr),   32'h20);
         chk($sformatf("wait%0d_ir", c),    32'(instr_out),   32'h0);
         chk($sformatf("wait%0d_valid", c), 32'(instr_valid), 32'h0);
      end
      feed(17'h0C00A);
      // Execute stalls two cycles; stray imem_valid in ISSUE is ignored
      for (int c = 0; c < 2; c++) begin
         imem_valid = 1'b1;
         imem_data  = 17'h1FFFF;
         tick();
         chk($sformatf("stall%0d_valid", c), 32'(instr_valid), 32'h1);
         chk($sformatf("stall%0d_ir", c),    32'(instr_out),   32'h0C00A);
         chk($sformatf("stall%0d_noreq", c), 32'(imem_req),    32'h0);
      end
      imem_valid = 1'b0;
      retire(BS_INC, 1'b0, 1'b0, 8'h00);
      chk("stall_next_addr", 32'(imem_addr), 32'h21);

      // Reset mid-FETCH, then a late valid while in IDLE
      tick();
      chk("midrst_req_before", 32'(imem_req), 32'h1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("midrst_req",   32'(imem_req),  32'h0);
      chk("midrst_state", 32'(state_dbg), 32'(S_IDLE));
      chk("midrst_pcout", 32'(pc_out),    32'h0);
      chk("midrst_ir",    32'(instr_out), 32'h0);
      chk("midrst_addr",  32'(imem_addr), 32'h0);
      imem_valid = 1'b1;
      imem_data  = 17'h0ABCD;
      tick();
      imem_valid = 1'b0;
      chk("stale_state", 32'(state_dbg),   32'(S_FETCH));
      chk("stale_ir",    32'(instr_out),   32'h0);
      chk("stale_valid", 32'(instr_valid), 32'h0);
      chk("stale_addr",  32'(imem_addr),   32'h0);
      feed(17'h02222);
      chk("post_rst_ir",    32'(instr_out), 32'h02222);
      chk("post_rst_pcout", 32'(pc_out),    32'h0);
      retire(BS_INC, 1'b0, 1'b0, 8'h00);
      chk("post_rst_next", 32'(imem_addr), 32'h1);

      // Opcode 20 is always legal
      feed(17'h14000);
      chk("op20_valid",   32'(instr_valid), 32'h1);
      chk("op20_illegal", 32'(illegal),     32'h0);
      retire(BS_INC, 1'b0, 1'b0, 8'h00);
      chk("op20_next", 32'(imem_addr), 32'h2);

      // Opcode 21
      feed(17'h15000);
`ifdef IFETCH_ILLEGAL_TRAP_EN
      chk("op21_illegal", 32'(illegal),     32'h1);
      chk("op21_valid",   32'(instr_valid), 32'h0);
      chk("op21_state",   32'(state_dbg),   32'(S_TRAP));
      tick();
      chk("op21_illegal_drop", 32'(illegal),     32'h0);
      chk("op21_valid_after",  32'(instr_valid), 32'h0);
      chk("op21_trap_addr",    32'(imem_addr),   32'hFF);
      chk("op21_trap_req",     32'(imem_req),    32'h1);
`else
      chk("op21_valid",   32'(instr_valid), 32'h1);
      chk("op21_illegal", 32'(illegal),     32'h0);
      chk("op21_ir",      32'(instr_out),   32'h15000);
      chk("op21_pcout",   32'(pc_out),      32'h2);
      retire(BS_INC, 1'b0, 1'b0, 8'h00);
      chk("op21_next", 32'(imem_addr), 32'h3);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
